// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// Results are computed at accept, held in pending flops, and committed after N busy cycles.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
  assign prod_u = {32'b0, A1} * {32'b0, A2};

  // One shared unsigned divider: signed DIV divides magnitudes and fixes signs after.
  logic        is_sdiv, div_zero;
  logic [31:0] mag_a, mag_b, num, den, q_raw, r_raw, q_res, r_res;
  assign is_sdiv  = (md_op == OP_DIV);
  assign div_zero = (A2 == 32'd0);
  assign mag_a    = A1[31] ? (32'd0 - A1) : A1;
  assign mag_b    = A2[31] ? (32'd0 - A2) : A2;
  assign num      = is_sdiv ? mag_a : A1;
  assign den      = div_zero ? 32'd1 : (is_sdiv ? mag_b : A2);
  assign q_raw    = num / den;
  assign r_raw    = num % den;
  assign q_res    = (is_sdiv && (A1[31] ^ A2[31])) ? (32'd0 - q_raw) : q_raw;
  assign r_res    = (is_sdiv && A1[31]) ? (32'd0 - r_raw) : r_raw;

  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      // In-flight ops are committed; req cannot cancel them.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (start && !req) begin
      case (md_op_e'(md_op))
        OP_MULT: begin
          {pend_hi, pend_lo} <= prod_s;
          pend_wr <= 1'b1;
          cnt     <= MUL_N;
        end
        OP_MULTU: begin
          {pend_hi, pend_lo} <= prod_u;
          pend_wr <= 1'b1;
          cnt     <= MUL_N;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi <= r_res;
          pend_lo <= q_res;
          pend_wr <= !div_zero;
          cnt     <= DIV_N;
        end
        OP_MTHI: HI <= A1;
        OP_MTLO: LO <= A1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: timestamp-based reference model compared every cycle,
// directed cases with literal expectations, then randomized instruction streams.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a1, a2;
  logic        req;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A1(a1), .A2(a2), .req(req), .busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted MD op is outstanding until edge (accept + N);
  // results come straight from 64-bit integer arithmetic.
  longint      cyc = 0;
  longint      done_cyc = 0;
  bit          active = 1'b0;
  bit [31:0]   e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;

  task automatic model_accept();
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a1));
    sb = longint'($signed(a2));
    ua = {32'b0, a1};
    ub = {32'b0, a2};
    case (md_op)
      3'd1: begin sq = sa * sb; {p_hi, p_lo} = sq; p_wr = 1'b1; done_cyc = cyc + MC; active = 1'b1; end
      3'd2: begin up = ua * ub; {p_hi, p_lo} = up; p_wr = 1'b1; done_cyc = cyc + MC; active = 1'b1; end
      3'd3: begin
        p_wr = (a2 != 0);
        if (p_wr) begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
        done_cyc = cyc + DC; active = 1'b1;
      end
      3'd4: begin
        p_wr = (a2 != 0);
        if (p_wr) begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        done_cyc = cyc + DC; active = 1'b1;
      end
      3'd5: e_hi = a1;
      3'd6: e_lo = a1;
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active = 1'b0; e_hi = '0; e_lo = '0; p_wr = 1'b0;
    end else begin
      cyc++;
      if (active) begin
        if (cyc == done_cyc) begin
          active = 1'b0;
          if (p_wr) begin e_hi = p_hi; e_lo = p_lo; end
        end
      end else if (start && !req) begin
        model_accept();
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_busy", {31'b0, busy}, {31'b0, active});
      chk("cmp_hi", hi, e_hi);
      chk("cmp_lo", lo, e_lo);
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic r);
    start = 1'b1; md_op = op; a1 = x; a2 = y; req = r;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: rnd_val = 32'h0000_0000;
      1: rnd_val = 32'hFFFF_FFFF;
      2: rnd_val = 32'h8000_0000;
      3: rnd_val = 32'($urandom_range(0, 20));
      default: rnd_val = $urandom;
    endcase
  endfunction

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; a1 = '0; a2 = '0; req = 1'b0;
    cmp_en = 1'b1;
    #22 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(n);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd2, 1'b0);
    count_busy(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    issue(3'd1, 32'd9, 32'd9, 1'b1);
    chk("req_mult_busy", {31'b0, busy}, 32'd0);
    chk("req_mult_hi", hi, 32'h1234_5678);
    chk("req_mult_lo", lo, 32'h9ABC_DEF0);

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    req = 1'b1;
    count_busy(n);
    req = 1'b0;
    chk("req_div_cycles", 32'(n), 32'd10);
    chk("req_div_lo", lo, 32'd14);
    chk("req_div_hi", hi, 32'd2);

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    issue(3'd3, 32'd5, 32'd0, 1'b0);
    count_busy(n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #10 reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("rst_late_busy", {31'b0, busy}, 32'd0);
    chk("rst_late_hi", hi, 32'd0);
    chk("rst_late_lo", lo, 32'd0);

    for (int i = 0; i < 600; i++) begin
      if (!busy && $urandom_range(0, 2) != 0) begin
        start = 1'b1;
        md_op = 3'($urandom_range(0, 7));
        a1 = rnd_val();
        a2 = rnd_val();
      end else begin
        start = 1'b0;
        md_op = 3'd0;
        a1 = $urandom;
        a2 = $urandom;
      end
      req = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; req = 1'b0;
    count_busy(n);
    chk("final_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
